// File: rtl/swu_pkg.sv
// Shared types and elaboration-time helpers for the sliding-window unit.
package swu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int ofm_dim(input int ifm_dim, input int k, input int stride);
    return (ifm_dim - k) / stride + 1;
  endfunction

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/swu_win_counter.sv
// Nested kx/ky/ox/oy window walker. Frame index and window base are kept as
// running sums so that no multiplier is needed.
module swu_win_counter
  import swu_pkg::*;
#(
  parameter int IFM_DIM = 8,
  parameter int K       = 3,
  parameter int STRIDE  = 1,
  parameter int IDX_W   = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             step,
  output logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] base,
  output logic             window_last,
  output logic             frame_last
);

  localparam int OFM = ofm_dim(IFM_DIM, K, STRIDE);
  localparam int KW  = clog2(K + 1);
  localparam int OW  = clog2(OFM + 1);
  localparam logic [IDX_W-1:0] COL_STEP  = IDX_W'(STRIDE);
  localparam logic [IDX_W-1:0] LINE_STEP = IDX_W'(IFM_DIM);
  localparam logic [IDX_W-1:0] ROW_STEP  = IDX_W'(STRIDE * IFM_DIM);

  logic [KW-1:0]    kx_reg, ky_reg;
  logic [OW-1:0]    ox_reg, oy_reg;
  logic [IDX_W-1:0] row_base_reg, win_base_reg, line_base_reg, idx_reg;
  logic             kx_max, ky_max, ox_max, oy_max;

  assign kx_max = (kx_reg == KW'(K - 1));
  assign ky_max = (ky_reg == KW'(K - 1));
  assign ox_max = (ox_reg == OW'(OFM - 1));
  assign oy_max = (oy_reg == OW'(OFM - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kx_reg        <= '0;
      ky_reg        <= '0;
      ox_reg        <= '0;
      oy_reg        <= '0;
      row_base_reg  <= '0;
      win_base_reg  <= '0;
      line_base_reg <= '0;
      idx_reg       <= '0;
    end else if (clear) begin
      kx_reg        <= '0;
      ky_reg        <= '0;
      ox_reg        <= '0;
      oy_reg        <= '0;
      row_base_reg  <= '0;
      win_base_reg  <= '0;
      line_base_reg <= '0;
      idx_reg       <= '0;
    end else if (step) begin
      if (!kx_max) begin
        kx_reg  <= kx_reg + KW'(1);
        idx_reg <= idx_reg + IDX_W'(1);
      end else begin
        kx_reg <= '0;
        if (!ky_max) begin
          ky_reg        <= ky_reg + KW'(1);
          line_base_reg <= line_base_reg + LINE_STEP;
          idx_reg       <= line_base_reg + LINE_STEP;
        end else begin
          ky_reg <= '0;
          if (!ox_max) begin
            ox_reg        <= ox_reg + OW'(1);
            win_base_reg  <= win_base_reg + COL_STEP;
            line_base_reg <= win_base_reg + COL_STEP;
            idx_reg       <= win_base_reg + COL_STEP;
          end else begin
            ox_reg <= '0;
            if (!oy_max) begin
              oy_reg        <= oy_reg + OW'(1);
              row_base_reg  <= row_base_reg + ROW_STEP;
              win_base_reg  <= row_base_reg + ROW_STEP;
              line_base_reg <= row_base_reg + ROW_STEP;
              idx_reg       <= row_base_reg + ROW_STEP;
            end else begin
              oy_reg        <= '0;
              row_base_reg  <= '0;
              win_base_reg  <= '0;
              line_base_reg <= '0;
              idx_reg       <= '0;
            end
          end
        end
      end
    end
  end

  assign idx         = idx_reg;
  assign base        = win_base_reg;
  assign window_last = kx_max & ky_max;
  assign frame_last  = kx_max & ky_max & ox_max & oy_max;

endmodule

// File: rtl/swu_read_ctrl.sv
// Read side of the sliding-window unit: walks the windows of one frame out of
// the circular buffer and streams the two-stage read pipeline as AXI-Stream.
module swu_read_ctrl
  import swu_pkg::*;
#(
  parameter int ELEM_W  = 8,
  parameter int IFM_DIM = 8,
  parameter int K       = 3,
  parameter int STRIDE  = 1,
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6,
  parameter int IDX_W   = 7
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [IDX_W-1:0]  wr_count,
  output logic [IDX_W-1:0]  rd_low,
  output logic              frame_done,
  output logic [ADDR_W-1:0] addrB,
  output logic              enaB,
  output logic              enaB_q,
  input  logic [ELEM_W-1:0] doB,
  output logic [ELEM_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast
);

  localparam logic [IDX_W-1:0] ADDR_MASK = IDX_W'(DEPTH - 1);

  state_t           state_reg, state_next;
  logic             v1_reg, v2_reg, l1_reg, l2_reg;
  logic             advance, issue, step;
  logic [IDX_W-1:0] idx, base;
  logic             window_last, frame_last;

  // The final beat does not step the walker, so rd_low keeps protecting the
  // last window until the pipeline has drained.
  assign step = issue & ~frame_last;

  swu_win_counter #(
    .IFM_DIM(IFM_DIM),
    .K      (K),
    .STRIDE (STRIDE),
    .IDX_W  (IDX_W)
  ) u_win_counter (
    .clk        (ap_clk),
    .rst_n      (ap_rst_n),
    .clear      (frame_done),
    .step       (step),
    .idx        (idx),
    .base       (base),
    .window_last(window_last),
    .frame_last (frame_last)
  );

  assign advance = ~v2_reg | m_axis_tready;
  assign issue   = (state_reg == RUN) & (idx < wr_count) & advance;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_reg <= IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (wr_count != '0) state_next = RUN;
      RUN:     if (issue && frame_last) state_next = DRAIN;
      DRAIN:   if (!v1_reg && !v2_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    enaB       = 1'b0;
    enaB_q     = 1'b0;
    frame_done = 1'b0;
    unique case (state_reg)
      RUN: begin
        enaB   = issue;
        enaB_q = advance;
      end
      DRAIN: begin
        enaB_q     = advance;
        frame_done = ~v1_reg & ~v2_reg;
      end
      default: ;
    endcase
  end

  // v1 shadows the buffer's internal read register, v2 its output register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
      l1_reg <= 1'b0;
      l2_reg <= 1'b0;
    end else if (advance) begin
      v1_reg <= issue;
      l1_reg <= issue & window_last;
      v2_reg <= v1_reg;
      l2_reg <= l1_reg;
    end
  end

  assign addrB         = ADDR_W'(idx & ADDR_MASK);
  assign rd_low        = base;
  assign m_axis_tdata  = doB;
  assign m_axis_tvalid = v2_reg;
  assign m_axis_tlast  = l2_reg;

endmodule

// File: tb/tb_swu_read_ctrl.sv
// Bench for swu_read_ctrl: a 4x4/K2/S1 instance driven by a vector table and
// scoreboards, and an 8x8/K3/S2 instance exercising circular wrap and backpressure.
module tb_swu_read_ctrl;

  localparam int A_IFM = 4, A_K = 2, A_S = 1, A_DEPTH = 16, A_AW = 4, A_IW = 5;
  localparam int B_IFM = 8, B_K = 3, B_S = 2, B_DEPTH = 32, B_AW = 5, B_IW = 7;
  localparam int A_BEATS = 36, B_BEATS = 81;

  typedef struct {
    int wr;
    bit tr;
    int addr;
    bit ena;
    bit enaq;
    bit tv;
    bit tl;
    int dat;
    int rdl;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [A_IW-1:0] wr_a, rd_low_a;
  logic [A_AW-1:0] addr_a;
  logic [7:0]      dob_a, tdata_a, rdb_a;
  logic            fd_a, ena_a, enaq_a, tv_a, tr_a, tl_a;

  logic [B_IW-1:0] wr_b, rd_low_b;
  logic [B_AW-1:0] addr_b;
  logic [7:0]      dob_b, tdata_b, rdb_b;
  logic            fd_b, ena_b, enaq_b, tv_b, tr_b, tl_b;

  logic [7:0] mem_a [A_DEPTH];
  logic [7:0] mem_b [B_DEPTH];

  int n_vec = 0, n_bad = 0;
  int a_iss = 0, a_beat = 0, a_fd_total = 0;
  int b_iss = 0, b_beat = 0, b_fd_total = 0;
  bit b_hold = 0;
  logic       hold_tl;
  logic [7:0] hold_data;
  vec_t vecs [14];

  swu_read_ctrl #(.ELEM_W(8), .IFM_DIM(A_IFM), .K(A_K), .STRIDE(A_S), .DEPTH(A_DEPTH),
                  .ADDR_W(A_AW), .IDX_W(A_IW)) dut_a (
    .ap_clk(clk), .ap_rst_n(rst_n), .wr_count(wr_a), .rd_low(rd_low_a), .frame_done(fd_a),
    .addrB(addr_a), .enaB(ena_a), .enaB_q(enaq_a), .doB(dob_a), .m_axis_tdata(tdata_a),
    .m_axis_tvalid(tv_a), .m_axis_tready(tr_a), .m_axis_tlast(tl_a));

  swu_read_ctrl #(.ELEM_W(8), .IFM_DIM(B_IFM), .K(B_K), .STRIDE(B_S), .DEPTH(B_DEPTH),
                  .ADDR_W(B_AW), .IDX_W(B_IW)) dut_b (
    .ap_clk(clk), .ap_rst_n(rst_n), .wr_count(wr_b), .rd_low(rd_low_b), .frame_done(fd_b),
    .addrB(addr_b), .enaB(ena_b), .enaB_q(enaq_b), .doB(dob_b), .m_axis_tdata(tdata_b),
    .m_axis_tvalid(tv_b), .m_axis_tready(tr_b), .m_axis_tlast(tl_b));

  // Buffer read port B: read register then output register.
  always @(posedge clk) begin
    if (ena_a)  rdb_a <= mem_a[addr_a];
    if (enaq_a) dob_a <= rdb_a;
    if (ena_b)  rdb_b <= mem_b[addr_b];
    if (enaq_b) dob_b <= rdb_b;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int beat_idx(input int ifm, input int k, input int s, input int n);
    int ofm, kx, ky, ox, oy;
    ofm = (ifm - k) / s + 1;
    kx = n % k;
    ky = (n / k) % k;
    ox = (n / (k * k)) % ofm;
    oy = n / (k * k * ofm);
    return oy * s * ifm + ox * s + ky * ifm + kx;
  endfunction

  function automatic int win_base(input int ifm, input int k, input int s, input int n);
    int ofm, ox, oy;
    ofm = (ifm - k) / s + 1;
    ox = (n / (k * k)) % ofm;
    oy = n / (k * k * ofm);
    return oy * s * ifm + ox * s;
  endfunction

  function automatic bit is_last(input int k, input int n);
    return (n % (k * k)) == k * k - 1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      a_iss = 0;
      a_beat = 0;
    end else begin
      if (ena_a) begin
        chk("a_addrB", addr_a, beat_idx(A_IFM, A_K, A_S, a_iss) % A_DEPTH);
        chk("a_rd_low", rd_low_a, win_base(A_IFM, A_K, A_S, a_iss));
        a_iss++;
      end
      if (tv_a && tr_a) begin
        chk("a_tdata", tdata_a, mem_a[beat_idx(A_IFM, A_K, A_S, a_beat) % A_DEPTH]);
        chk("a_tlast", tl_a, is_last(A_K, a_beat));
        a_beat++;
      end
      if (fd_a) begin
        chk("a_beats_at_done", a_beat, A_BEATS);
        chk("a_issues_at_done", a_iss, A_BEATS);
        a_fd_total++;
        a_beat = 0;
        a_iss = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      b_iss = 0;
      b_beat = 0;
      b_hold = 0;
    end else begin
      if (b_hold) chk("b_stall_hold", {tv_b, tl_b, tdata_b}, {1'b1, hold_tl, hold_data});
      b_hold = tv_b && !tr_b;
      hold_tl = tl_b;
      hold_data = tdata_b;
      if (ena_b) begin
        chk("b_addrB", addr_b, beat_idx(B_IFM, B_K, B_S, b_iss) % B_DEPTH);
        chk("b_rd_low", rd_low_b, win_base(B_IFM, B_K, B_S, b_iss));
        b_iss++;
      end
      if (tv_b && tr_b) begin
        chk("b_tdata", tdata_b, mem_b[beat_idx(B_IFM, B_K, B_S, b_beat) % B_DEPTH]);
        chk("b_tlast", tl_b, is_last(B_K, b_beat));
        b_beat++;
      end
      if (fd_b) begin
        chk("b_beats_at_done", b_beat, B_BEATS);
        b_fd_total++;
        b_beat = 0;
        b_iss = 0;
      end
    end
  end

  initial begin
    bit seen;
    for (int i = 0; i < A_DEPTH; i++) mem_a[i] = 8'(8'h30 + i * 7);
    for (int i = 0; i < B_DEPTH; i++) mem_b[i] = 8'(i * 5 + 1);
    //           wr tr addr ena enaq tv tl dat rdl
    vecs[0]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{5, 1, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{5, 1, 0, 1, 1, 0, 0, 0, 0};
    vecs[3]  = '{5, 1, 1, 1, 1, 0, 0, 0, 0};
    vecs[4]  = '{5, 1, 4, 1, 1, 1, 0, 0, 0};
    vecs[5]  = '{5, 1, 5, 0, 1, 1, 0, 1, 0};
    vecs[6]  = '{5, 1, 5, 0, 1, 1, 0, 4, 0};
    vecs[7]  = '{5, 1, 5, 0, 1, 0, 0, 0, 0};
    vecs[8]  = '{6, 1, 5, 1, 1, 0, 0, 0, 0};
    vecs[9]  = '{6, 1, 1, 1, 1, 0, 0, 0, 1};
    vecs[10] = '{6, 0, 2, 0, 0, 1, 1, 5, 1};
    vecs[11] = '{6, 0, 2, 0, 0, 1, 1, 5, 1};
    vecs[12] = '{6, 1, 2, 1, 1, 1, 1, 5, 1};
    vecs[13] = '{6, 1, 5, 1, 1, 1, 0, 1, 1};

    rst_n = 1'b0; wr_a = '0; tr_a = 1'b1; wr_b = '0; tr_b = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_a", {addr_a, ena_a, enaq_a, tv_a, tl_a, rd_low_a, fd_a}, '0);
    chk("reset_b", {addr_b, ena_b, enaq_b, tv_b, tl_b, rd_low_b, fd_b}, '0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      wr_a = A_IW'(vecs[i].wr);
      tr_a = vecs[i].tr;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {addr_a, ena_a, enaq_a, tv_a, tl_a, rd_low_a, fd_a},
          {A_AW'(vecs[i].addr), vecs[i].ena, vecs[i].enaq, vecs[i].tv, vecs[i].tl,
           A_IW'(vecs[i].rdl), 1'b0});
      if (vecs[i].tv) chk($sformatf("vec%0d_tdata", i), tdata_a, mem_a[vecs[i].dat]);
    end

    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(posedge clk); #1 wr_a = A_IW'(16); tr_a = 1'b1;
      @(negedge clk);
      if (fd_a) seen = 1;
    end
    chk("a_frame_done_seen", seen, 1);
    @(posedge clk); #1 wr_a = '0;
    @(negedge clk);
    chk("a_idle_after_done", {rd_low_a, tv_a, ena_a, fd_a}, '0);
    repeat (3) @(negedge clk);
    chk("a_single_frame_done", a_fd_total, 1);

    seen = 0;
    for (int c = 0; c < 600 && !seen; c++) begin
      @(posedge clk); #1 wr_b = B_IW'(64); tr_b = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (fd_b) seen = 1;
    end
    chk("b_frame_done_seen", seen, 1);
    @(posedge clk); #1 wr_b = '0; tr_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("b_single_frame_done", b_fd_total, 1);

    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1 wr_a = A_IW'(16); tr_a = 1'b1;
    end
    @(negedge clk);
    chk("a_busy_before_reset", tv_a, 1);
    #2 rst_n = 1'b0;
    #1 chk("a_async_reset", {addr_a, ena_a, enaq_a, tv_a, tl_a, rd_low_a, fd_a}, '0);
    wr_a = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("a_idle_after_reset", {ena_a, tv_a, fd_a}, '0);

    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(posedge clk); #1 wr_a = A_IW'(16); tr_a = 1'b1;
      @(negedge clk);
      if (fd_a) seen = 1;
    end
    chk("a_restart_frame_done_seen", seen, 1);
    @(posedge clk); #1 wr_a = '0;
    repeat (3) @(negedge clk);
    chk("a_frame_done_total", a_fd_total, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
